// File: rtl/decrypt_pkg.sv
// Shared types and constants for the decryption dispatcher and its output mux.
package decrypt_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDiscard,
    StWaitStart,
    StDrain
  } state_e;

  typedef enum logic [1:0] {
    ErrEmpty    = 2'd0,
    ErrBadSel   = 2'd1,
    ErrOverflow = 2'd2,
    ErrEngine   = 2'd3
  } err_code_e;

  localparam int unsigned CAESAR  = 0;
  localparam int unsigned SCYTALE = 1;
  localparam int unsigned ZIGZAG  = 2;

  localparam logic [7:0] DEFAULT_START_TOKEN = 8'hFA;

endpackage

// File: rtl/dispatch_out_mux.sv
// Registered select of the active engine's output stream, plus a count of characters
// delivered on data_o/valid_o since the last clear.
module dispatch_out_mux #(
  parameter int unsigned D_WIDTH     = 8,
  parameter int unsigned NUM_ENGINES = 3,
  parameter int unsigned CNT_WIDTH   = 6
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en_i,
  input  logic                           clr_i,
  input  logic [1:0]                     sel_i,
  input  logic [NUM_ENGINES*D_WIDTH-1:0] eng_data_i,
  input  logic [NUM_ENGINES-1:0]         eng_valid_i,
  output logic [D_WIDTH-1:0]             data_o,
  output logic                           valid_o,
  output logic [CNT_WIDTH-1:0]           cnt_next_o
);

  logic [D_WIDTH-1:0]   data_q, data_d;
  logic                 valid_q, valid_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    data_d  = '0;
    valid_d = 1'b0;
    cnt_d   = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end
    if (en_i && (32'(sel_i) < NUM_ENGINES)) begin
      data_d  = eng_data_i[32'(sel_i)*D_WIDTH +: D_WIDTH];
      valid_d = eng_valid_i[sel_i];
      if (valid_d) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign cnt_next_o = cnt_d;

endmodule

// File: rtl/decryption_dispatcher.sv
// Front-end sequencer: loads one message into the selected decryption engine, waits for it
// to run, and merges its output stream back onto a single port with done/error reporting.
module decryption_dispatcher
  import decrypt_pkg::*;
#(
  parameter int unsigned    D_WIDTH                = 8,
  parameter int unsigned    KEY_WIDTH              = 16,
  parameter int unsigned    NUM_ENGINES            = 3,
  parameter int unsigned    MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = D_WIDTH'(DEFAULT_START_TOKEN),
  parameter int unsigned    START_TIMEOUT          = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [D_WIDTH-1:0]             data_i,
  input  logic                           valid_i,
  input  logic [1:0]                     sel_i,
  input  logic [KEY_WIDTH-1:0]           key_i,
  output logic                           ready_o,
  output logic [D_WIDTH-1:0]             eng_data_o,
  output logic [NUM_ENGINES-1:0]         eng_valid_o,
  output logic [KEY_WIDTH-1:0]           eng_key_o,
  input  logic [NUM_ENGINES-1:0]         eng_busy_i,
  input  logic [NUM_ENGINES*D_WIDTH-1:0] eng_data_i,
  input  logic [NUM_ENGINES-1:0]         eng_valid_i,
  output logic [D_WIDTH-1:0]             data_o,
  output logic                           valid_o,
  output logic                           done_o,
  output logic                           err_o,
  output logic [1:0]                     err_code_o
);

  localparam int unsigned CntW = $clog2(MAX_NOF_CHARS + 1);
  localparam int unsigned TmoW = $clog2(START_TIMEOUT + 1);

  state_e               state_q, state_d;
  logic                 ready_q, ready_d;
  logic [1:0]           sel_q, sel_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [CntW-1:0]      in_cnt_q, in_cnt_d;
  logic                 ovf_q, ovf_d;
  logic [TmoW-1:0]      tmo_q, tmo_d;
  logic [D_WIDTH-1:0]   eng_data_q, eng_data_d;
  logic [NUM_ENGINES-1:0] eng_valid_q, eng_valid_d;
  logic                 err_q, err_d;
  err_code_e            err_code_q, err_code_d;
  logic                 done_q, done_d;

  logic                 accept;
  logic                 is_token;
  logic [CntW-1:0]      out_cnt_next;

  assign accept   = valid_i & ready_q;
  assign is_token = (data_i == START_DECRYPTION_TOKEN);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    key_d       = key_q;
    in_cnt_d    = in_cnt_q;
    ovf_d       = ovf_q;
    tmo_d       = tmo_q;
    eng_data_d  = '0;
    eng_valid_d = '0;
    err_d       = 1'b0;
    err_code_d  = ErrEmpty;
    done_d      = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_token) begin
            err_d      = 1'b1;
            err_code_d = ErrEmpty;
          end else if (32'(sel_i) >= NUM_ENGINES) begin
            err_d      = 1'b1;
            err_code_d = ErrBadSel;
            state_d    = StDiscard;
          end else begin
            sel_d       = sel_i;
            key_d       = key_i;
            eng_data_d  = data_i;
            eng_valid_d = NUM_ENGINES'(1) << sel_i;
            in_cnt_d    = CntW'(1);
            ovf_d       = 1'b0;
            state_d     = StLoad;
          end
        end
      end
      StLoad: begin
        if (accept) begin
          if (is_token) begin
            eng_data_d  = data_i;
            eng_valid_d = NUM_ENGINES'(1) << sel_q;
            tmo_d       = '0;
            state_d     = StWaitStart;
          end else if (in_cnt_q < CntW'(MAX_NOF_CHARS)) begin
            eng_data_d  = data_i;
            eng_valid_d = NUM_ENGINES'(1) << sel_q;
            in_cnt_d    = in_cnt_q + CntW'(1);
          end else if (!ovf_q) begin
            // Only the first dropped character of a message is reported.
            err_d      = 1'b1;
            err_code_d = ErrOverflow;
            ovf_d      = 1'b1;
          end
        end
      end
      StDiscard: begin
        if (accept && is_token) begin
          state_d = StIdle;
        end
      end
      StWaitStart: begin
        if (eng_busy_i[sel_q]) begin
          state_d = StDrain;
        end else if (tmo_q == TmoW'(START_TIMEOUT - 1)) begin
          err_d      = 1'b1;
          err_code_d = ErrEngine;
          state_d    = StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StDrain: begin
        if (!eng_busy_i[sel_q]) begin
          // Include a character the engine hands over on the same cycle busy drops.
          if (out_cnt_next == in_cnt_q) begin
            done_d = 1'b1;
          end else begin
            err_d      = 1'b1;
            err_code_d = ErrEngine;
          end
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    ready_d = (state_d == StIdle) || (state_d == StLoad) || (state_d == StDiscard);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ready_q     <= 1'b1;
      sel_q       <= '0;
      key_q       <= '0;
      in_cnt_q    <= '0;
      ovf_q       <= 1'b0;
      tmo_q       <= '0;
      eng_data_q  <= '0;
      eng_valid_q <= '0;
      err_q       <= 1'b0;
      err_code_q  <= ErrEmpty;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      sel_q       <= sel_d;
      key_q       <= key_d;
      in_cnt_q    <= in_cnt_d;
      ovf_q       <= ovf_d;
      tmo_q       <= tmo_d;
      eng_data_q  <= eng_data_d;
      eng_valid_q <= eng_valid_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      done_q      <= done_d;
    end
  end

  dispatch_out_mux #(
    .D_WIDTH    (D_WIDTH),
    .NUM_ENGINES(NUM_ENGINES),
    .CNT_WIDTH  (CntW)
  ) u_out_mux (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (state_q == StDrain),
    .clr_i      (state_q == StIdle),
    .sel_i      (sel_q),
    .eng_data_i (eng_data_i),
    .eng_valid_i(eng_valid_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .cnt_next_o (out_cnt_next)
  );

  assign ready_o     = ready_q;
  assign eng_data_o  = eng_data_q;
  assign eng_valid_o = eng_valid_q;
  assign eng_key_o   = key_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;

endmodule

// File: tb/tb_decryption_dispatcher.sv
// Directed bench for decryption_dispatcher with simple caesar/zigzag engine models attached.
module tb_decryption_dispatcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data_i;
  logic        valid_i;
  logic [1:0]  sel_i;
  logic [15:0] key_i;
  logic        ready_o;
  logic [7:0]  eng_data_o;
  logic [2:0]  eng_valid_o;
  logic [15:0] eng_key_o;
  logic [2:0]  eng_busy;
  logic [23:0] eng_data_m;
  logic [2:0]  eng_valid_m;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        done_o;
  logic        err_o;
  logic [1:0]  err_code_o;

  always #5 clk = ~clk;

  decryption_dispatcher dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .sel_i      (sel_i),
    .key_i      (key_i),
    .ready_o    (ready_o),
    .eng_data_o (eng_data_o),
    .eng_valid_o(eng_valid_o),
    .eng_key_o  (eng_key_o),
    .eng_busy_i (eng_busy),
    .eng_data_i (eng_data_m),
    .eng_valid_i(eng_valid_m),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .err_code_o (err_code_o)
  );

  // ---------------- engine models ----------------
  logic [7:0] m_in[$];
  logic [7:0] m_out[$];
  int         m_act;
  bit         no_busy1;

  function automatic int onehot_idx(input logic [2:0] oh);
    if (oh[0]) return 0;
    if (oh[1]) return 1;
    return 2;
  endfunction

  task automatic model_decrypt(input int e, input logic [15:0] key);
    logic [7:0] res [64];
    int n, idx, cyc, m, rl;
    n = m_in.size();
    if (e == 0) begin
      for (int i = 0; i < n; i++) m_out.push_back(m_in[i] - key[7:0]);
    end else if (e == 2 && key >= 2) begin
      idx = 0;
      cyc = 2 * (int'(key) - 1);
      for (int rr = 0; rr < int'(key); rr++) begin
        for (int p = 0; p < n; p++) begin
          m  = p % cyc;
          rl = (m < int'(key)) ? m : cyc - m;
          if (rl == rr) begin
            res[p] = m_in[idx];
            idx++;
          end
        end
      end
      for (int p = 0; p < n; p++) m_out.push_back(res[p]);
    end else begin
      for (int i = 0; i < n; i++) m_out.push_back(m_in[i]);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      eng_busy    <= '0;
      eng_valid_m <= '0;
      eng_data_m  <= '0;
      m_act       <= 0;
      m_in.delete();
      m_out.delete();
    end else begin
      eng_valid_m <= '0;
      if (eng_valid_o != 3'b000) begin
        if (eng_data_o == 8'hFA) begin
          if (!(no_busy1 && eng_valid_o == 3'b010)) begin
            model_decrypt(onehot_idx(eng_valid_o), eng_key_o);
            eng_busy[onehot_idx(eng_valid_o)] <= 1'b1;
            m_act <= onehot_idx(eng_valid_o);
          end
          m_in.delete();
        end else begin
          m_in.push_back(eng_data_o);
        end
      end else if (eng_busy[m_act]) begin
        if (m_out.size() > 0) begin
          eng_data_m[m_act*8 +: 8] <= m_out.pop_front();
          eng_valid_m[m_act]       <= 1'b1;
        end else begin
          eng_busy[m_act] <= 1'b0;
        end
      end
    end
  end

  // ---------------- observation ----------------
  int vecs, fails;
  int cyc, fwd_cnt, err_cnt, done_cnt, both_cnt, err_cyc, last_send_cyc;
  logic [1:0] last_code;
  logic [2:0] fwd_mask;
  logic [7:0] obs[$];

  task automatic clear_mon();
    fwd_cnt = 0; err_cnt = 0; done_cnt = 0; both_cnt = 0; err_cyc = -1;
    last_code = 2'd0; fwd_mask = 3'b000; obs.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (eng_valid_o != 3'b000) begin
      fwd_cnt++;
      fwd_mask = fwd_mask | eng_valid_o;
    end
    if (valid_o) obs.push_back(data_o);
    if (err_o) begin
      err_cnt++;
      err_cyc   = cyc;
      last_code = err_code_o;
    end
    if (done_o) done_cnt++;
    if (err_o && done_o) both_cnt++;
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] s, input logic [15:0] k);
    valid_i = 1'b1; data_i = d; sel_i = s; key_i = k;
    tick();
    valid_i = 1'b0;
    last_send_cyc = cyc;
  endtask

  task automatic wait_end(input int budget);
    int start, n;
    start = done_cnt + err_cnt;
    n = 0;
    while (done_cnt + err_cnt == start && n < budget) begin
      tick();
      n++;
    end
    vecs++;
    if (done_cnt + err_cnt == start) begin
      fails++;
      $display("FAIL wait_end: no done/err within %0d cycles", budget);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    vecs++; if (ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    vecs++; if ({valid_o, done_o, err_o, err_code_o} !== 5'b0) begin
      fails++; $display("FAIL reset_flags: got %b want 00000", {valid_o, done_o, err_o, err_code_o});
    end
    vecs++; if ({eng_valid_o, eng_data_o, eng_key_o, data_o} !== 35'b0) begin
      fails++; $display("FAIL reset_buses: got %h want 0", {eng_valid_o, eng_data_o, eng_key_o, data_o});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_zigzag();
    logic [31:0] got;
    clear_mon();
    send("A", 2'd2, 16'd3);
    send("B", 2'd0, 16'd9);  // sel/key changes after the first char must be ignored
    send("D", 2'd1, 16'd7);
    send("C", 2'd2, 16'd3);
    send(8'hFA, 2'd2, 16'd3);
    vecs++; if (eng_key_o !== 16'd3) begin fails++; $display("FAIL zz_key: got %0d want 3", eng_key_o); end
    wait_end(40);
    vecs++; if (fwd_cnt !== 5) begin fails++; $display("FAIL zz_fwd_cnt: got %0d want 5", fwd_cnt); end
    vecs++; if (fwd_mask !== 3'b100) begin fails++; $display("FAIL zz_fwd_mask: got %b want 100", fwd_mask); end
    vecs++; if (done_cnt !== 1 || err_cnt !== 0) begin
      fails++; $display("FAIL zz_done: got done=%0d err=%0d want 1/0", done_cnt, err_cnt);
    end
    got = 32'h0;
    for (int i = 0; i < obs.size() && i < 4; i++) got = {got[23:0], obs[i]};
    vecs++; if (obs.size() !== 4 || got !== "ABCD") begin
      fails++; $display("FAIL zz_out: got %0d chars %h want 4 chars %h", obs.size(), got, "ABCD");
    end
    vecs++; if (ready_o !== 1'b1) begin fails++; $display("FAIL zz_ready: got %b want 1", ready_o); end
  endtask

  task automatic test_bad_sel();
    int x_cyc;
    clear_mon();
    send("X", 2'd3, 16'd0);
    x_cyc = last_send_cyc;
    send("Y", 2'd3, 16'd0);
    send(8'hFA, 2'd3, 16'd0);
    tick();
    vecs++; if (err_cnt !== 1 || last_code !== 2'd1) begin
      fails++; $display("FAIL badsel_err: got cnt=%0d code=%0d want 1/1", err_cnt, last_code);
    end
    vecs++; if (err_cyc !== x_cyc) begin fails++; $display("FAIL badsel_when: got %0d want %0d", err_cyc, x_cyc); end
    vecs++; if (fwd_cnt !== 0) begin fails++; $display("FAIL badsel_fwd: got %0d want 0", fwd_cnt); end
    vecs++; if (ready_o !== 1'b1) begin fails++; $display("FAIL badsel_ready: got %b want 1", ready_o); end
  endtask

  task automatic test_empty();
    clear_mon();
    send(8'hFA, 2'd0, 16'd0);
    tick();
    vecs++; if (err_cnt !== 1 || last_code !== 2'd0) begin
      fails++; $display("FAIL empty_err: got cnt=%0d code=%0d want 1/0", err_cnt, last_code);
    end
    vecs++; if (fwd_cnt !== 0) begin fails++; $display("FAIL empty_fwd: got %0d want 0", fwd_cnt); end
  endtask

  task automatic test_overflow();
    int c51;
    clear_mon();
    c51 = -2;
    for (int i = 0; i < 52; i++) begin
      send(8'h41 + 8'(i), 2'd0, 16'd1);
      if (i == 50) c51 = last_send_cyc;
    end
    send(8'hFA, 2'd0, 16'd1);
    vecs++; if (fwd_cnt !== 51) begin fails++; $display("FAIL ovf_fwd: got %0d want 51", fwd_cnt); end
    vecs++; if (err_cnt !== 1 || last_code !== 2'd2) begin
      fails++; $display("FAIL ovf_err: got cnt=%0d code=%0d want 1/2", err_cnt, last_code);
    end
    vecs++; if (err_cyc !== c51) begin fails++; $display("FAIL ovf_when: got %0d want %0d", err_cyc, c51); end
    wait_end(200);
    vecs++; if (done_cnt !== 1 || err_cnt !== 1) begin
      fails++; $display("FAIL ovf_done: got done=%0d err=%0d want 1/1", done_cnt, err_cnt);
    end
    vecs++; if (obs.size() !== 50) begin fails++; $display("FAIL ovf_outlen: got %0d want 50", obs.size()); end
    if (obs.size() == 50) begin
      vecs++; if (obs[0] !== 8'h40 || obs[49] !== 8'h71) begin
        fails++; $display("FAIL ovf_outdata: got %h/%h want 40/71", obs[0], obs[49]);
      end
    end
  endtask

  task automatic test_timeout();
    int t;
    clear_mon();
    no_busy1 = 1'b1;
    send("H", 2'd1, 16'd2);
    send("I", 2'd1, 16'd2);
    send(8'hFA, 2'd1, 16'd2);
    t = last_send_cyc;
    valid_i = 1'b1; data_i = "Z"; sel_i = 2'd0;  // must be ignored while not ready
    wait_end(20);
    valid_i = 1'b0;
    vecs++; if (err_cnt !== 1 || last_code !== 2'd3) begin
      fails++; $display("FAIL tmo_err: got cnt=%0d code=%0d want 1/3", err_cnt, last_code);
    end
    vecs++; if (err_cyc - t !== 4) begin fails++; $display("FAIL tmo_when: got %0d want 4", err_cyc - t); end
    vecs++; if (fwd_cnt !== 3 || done_cnt !== 0 || ready_o !== 1'b1) begin
      fails++; $display("FAIL tmo_after: got fwd=%0d done=%0d ready=%b want 3/0/1", fwd_cnt, done_cnt, ready_o);
    end
    no_busy1 = 1'b0;
    tick();
  endtask

  task automatic test_reset_drain();
    int n;
    clear_mon();
    send("H", 2'd0, 16'd0);
    send("I", 2'd0, 16'd0);
    send(8'hFA, 2'd0, 16'd0);
    n = 0;
    while (obs.size() == 0 && n < 20) begin tick(); n++; end
    vecs++; if (obs.size() == 0) begin fails++; $display("FAIL rstd_drain: got no output want output"); end
    rst_n = 1'b0;
    tick();
    vecs++; if ({valid_o, done_o, err_o, eng_valid_o, data_o} !== 14'b0 || ready_o !== 1'b1) begin
      fails++; $display("FAIL rstd_outs: got %h ready=%b want 0/1", {valid_o, done_o, err_o, eng_valid_o, data_o}, ready_o);
    end
    rst_n = 1'b1;
    clear_mon();
    for (int i = 0; i < 6; i++) tick();
    vecs++; if (done_cnt !== 0 || err_cnt !== 0) begin
      fails++; $display("FAIL rstd_silent: got done=%0d err=%0d want 0/0", done_cnt, err_cnt);
    end
    send("J", 2'd0, 16'd2);
    send("K", 2'd0, 16'd2);
    send(8'hFA, 2'd0, 16'd2);
    wait_end(40);
    vecs++; if (done_cnt !== 1 || err_cnt !== 0 || both_cnt !== 0) begin
      fails++; $display("FAIL rstd_done: got done=%0d err=%0d want 1/0", done_cnt, err_cnt);
    end
    vecs++; if (obs.size() !== 2 || obs[0] !== "H" || obs[1] !== "I") begin
      fails++; $display("FAIL rstd_out: got %0d chars want HI", obs.size());
    end
  endtask

  initial begin
    vecs = 0; fails = 0; cyc = 0; last_send_cyc = 0;
    valid_i = 1'b0; data_i = '0; sel_i = '0; key_i = '0; no_busy1 = 1'b0;
    clear_mon();
    test_reset();
    test_zigzag();
    test_bad_sel();
    test_empty();
    test_overflow();
    test_timeout();
    test_reset_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/decryption_dispatcher.md
Name: decryption_dispatcher

Overview:
- Front-end controller that sequences and shares the decryption engines (caesar=0, scytale=1, zigzag=2).
- Accepts one encrypted message at a time plus an engine select and key, then streams the characters and the START token into the selected engine.
- Holds off upstream while the engine decrypts, then merges the engine's output stream onto a single output port and reports done or error.

Parameters:
D_WIDTH, 8, character width
KEY_WIDTH, 16, key width
NUM_ENGINES, 3, number of attached engines (index 0..NUM_ENGINES-1)
MAX_NOF_CHARS, 50, maximum message length accepted
START_DECRYPTION_TOKEN, 8'hFA, end-of-message / start-decryption character
START_TIMEOUT, 4, cycles allowed for selected engine to raise busy after token

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
data_i  in  D_WIDTH  encrypted character or token
valid_i  in  1  data_i qualifier; accepted only when ready_o=1
sel_i  in  2  engine select, sampled with first character
key_i  in  KEY_WIDTH  key, sampled with first character
ready_o  out  1  dispatcher can accept data_i
eng_data_o  out  D_WIDTH  shared character bus to all engines
eng_valid_o  out  NUM_ENGINES  one-hot valid to selected engine
eng_key_o  out  KEY_WIDTH  latched key to engines
eng_busy_i  in  NUM_ENGINES  engine busy flags
eng_data_i  in  NUM_ENGINES*D_WIDTH  engine outputs, engine e at [e*D_WIDTH +: D_WIDTH]
eng_valid_i  in  NUM_ENGINES  engine output valids
data_o  out  D_WIDTH  decrypted character
valid_o  out  1  data_o qualifier
done_o  out  1  one-cycle pulse, message completed cleanly
err_o  out  1  one-cycle pulse, error
err_code_o  out  2  valid with err_o: 0 empty message, 1 bad select, 2 overflow, 3 engine fault

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; ready_o=1; all other outputs, in_cnt, out_cnt and latched sel/key = 0. Reset mid-message aborts silently: no done_o, no err_o.
- Registered outputs only; no combinational input-to-output paths.
- IDLE (ready_o=1):
  - valid non-token char with sel_i<NUM_ENGINES: latch sel and key; forward the char; in_cnt=1; go LOAD.
  - sel_i>=NUM_ENGINES: err_o with code 1; go DISCARD.
  - token: err_o with code 0; stay IDLE; nothing forwarded.
- LOAD (ready_o=1):
  - Each valid char is forwarded 1 cycle later: eng_data_o=char, eng_valid_o=1<<sel, otherwise 0. sel_i and key_i changes are ignored.
  - in_cnt saturates at MAX_NOF_CHARS. A char arriving at the cap is dropped. The first drop pulses err_o with code 2, once per message.
  - Token: forward it; ready_o=0 next cycle; go WAIT_START.
- DISCARD (ready_o=1): drop chars until token; token dropped; go IDLE.
- WAIT_START (ready_o=0):
  - eng_busy_i[sel]=1: go DRAIN.
  - START_TIMEOUT cycles without busy: err_o with code 3; go IDLE.
- DRAIN (ready_o=0):
  - data_o/valid_o = eng_data_i/eng_valid_i of the selected engine, delayed 1 cycle; out_cnt counts valid_o. Other engines' outputs are ignored.
  - Busy falls: next cycle, if out_cnt==in_cnt, done_o=1; else err_o with code 3. Either way go IDLE with ready_o=1.
- eng_key_o is held stable from LOAD entry until return to IDLE.
- valid_i while ready_o=0: ignored, no state change.
- err_o and done_o are never asserted in the same cycle.

Decomposition:
- Package decrypt_pkg holds:
  - state encoding: IDLE, LOAD, DISCARD, WAIT_START, DRAIN
  - error codes
  - engine indices CAESAR=0, SCYTALE=1, ZIGZAG=2
  - default START_DECRYPTION_TOKEN
- One sub-module, dispatch_out_mux: registered select of eng_data_i/eng_valid_i by latched sel, with output valid counter.

Test Plan:
- sel=2, key=3, chars "ABCD" then 8'hFA, zigzag model attached → eng_valid_o=3'b100 for 5 cycles. Engine decrypts "ABCD" (rows "A","BD","C" → encrypted "ABDC" fed, yields "ABCD"); valid_o for 4 cycles, then done_o=1, err_o=0.
- sel=3, chars "XY", then 8'hFA → err_o=1 with code 1 on the cycle after "X"; no eng_valid_o; then IDLE, ready_o=1.
- sel=0, 52 chars then 8'hFA → 50 chars forwarded; err_o code 2 once, at the 51st char; token forwarded.
- Lone 8'hFA in IDLE → err_o code 0; eng_valid_o stays 0.
- sel=1, "HI"+8'hFA, engine model never raises busy → err_o code 3 exactly 4 cycles after busy expected; returns IDLE.
- rst_n=0 during DRAIN → next cycle all outputs 0, ready_o=1. A fresh sel=0 message then completes with done_o=1.
